led_sequencer: RTL and testbench
================================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0300_0100, is the register window base; the window is 256 bytes and decodes when iomem_addr[31:8] == BASE_ADDR[31:8].
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 iomem_valid  input  1  bus request.
REQ-005 iomem_wstrb  input  4  byte write strobes; all zero means read.
REQ-006 iomem_addr  input  32  byte address.
REQ-007 iomem_wdata  input  32  write data.
REQ-008 iomem_ready  output  1  one-cycle access acknowledge.
REQ-009 iomem_rdata  output  32  read data, valid only while iomem_ready=1, otherwise 0.
REQ-010 led  output  1  registered LED drive.

Function
REQ-011 Register map (offset, fields):
- 0x00 CTRL: [0] EN, [1] MODE (0=PWM only, 1=pattern), [2] LOOP; other bits read 0.
- 0x04 PRESCALE: [23:0]; the tick fires every PRESCALE+1 cycles.
- 0x08 PATTERN: [31:0].
- 0x0C DUTY: [7:0].
- 0x10 STATUS, read-only: [0] BUSY, [1] DONE (sticky; writing 1 to bit 1 clears it), [12:8] current bit index.
REQ-012 Handshake: a selected access with iomem_valid=1 and iomem_ready=0 produces iomem_ready=1 on the next cycle for exactly one cycle; writes commit on that same edge.
REQ-013 If iomem_valid drops before ready, the access is abandoned with no write and no ready.
REQ-014 Writes honour iomem_wstrb per byte lane; bits outside the defined fields are ignored.
REQ-015 Offsets 0x14-0xFC acknowledge normally, read 0, and ignore writes.
REQ-016 Unselected addresses never assert iomem_ready.
REQ-017 The sequencer FSM has three states: IDLE, RUN, DONE.
REQ-018 A CTRL write with EN=1 enters RUN from any state and clears the prescale counter, bit index, PWM counter and DONE; it also loads the shift copy from PATTERN.
REQ-019 A CTRL write with EN=0 forces IDLE, and led is 0 from the following cycle.
REQ-020 In RUN, the 8-bit PWM counter increments every cycle and wraps 255->0; pwm_on = (pwm_cnt < DUTY), so DUTY=0 gives always off.
REQ-021 Sequencing in RUN:
- Each tick advances the bit index by 1.
- On the tick at index 31: if LOOP=1, the index wraps to 0 and the shift copy reloads from the current PATTERN.
- If LOOP=0, the FSM enters DONE, DONE=1, EN clears to 0, and led is 0.
REQ-022 A PATTERN write during RUN does not alter the active shift copy until the next reload.
REQ-023 Registered LED value: led <= RUN & pwm_on & (MODE ? shift_copy[index] : 1); so led lags its inputs by one cycle.
REQ-024 When a CTRL write and a tick coincide, the CTRL write wins and the tick is discarded.
REQ-025 BUSY reads 1 exactly while in RUN.

Reset
REQ-026 With reset=1 at a clock edge, every register is cleared: CTRL, PRESCALE, PATTERN, DUTY, DONE, counters and index all go to 0, the FSM goes to IDLE, and led, iomem_ready and iomem_rdata go to 0.
REQ-027 Reset mid-access or mid-sequence aborts the operation without producing an acknowledge.

Verification
REQ-028 Read after reset of offsets 0x00-0x10 -> each returns 0, with ready exactly one cycle after valid.
REQ-029 DUTY=255, MODE=0, CTRL=0x1 -> led high for 255 of every 256 cycles; DUTY=128 -> 128 of 256.
REQ-030 PATTERN=0x0000_0005, PRESCALE=3, DUTY=255, CTRL=0x3 (no loop):
- led follows 1,0,1,0... for 4 cycles per bit, with PWM off-cycles masked.
- After 128 cycles: DONE=1, EN=0, led=0, STATUS=0x0000_0002 (index cleared to 0 on exit, DONE set).
REQ-031 Same setup with CTRL=0x7 (loop) and a PATTERN write of 0xFFFF_FFFF mid-sequence -> the old pattern completes and the new one starts at index 0.
REQ-032 Write with wstrb=4'b0001 of 0xAABB_CCDD to PATTERN -> PATTERN reads 0x0000_00DD; an access at BASE_ADDR+0x100 gets no ready.
REQ-033 Assert reset during RUN with a write pending -> no ready, led=0 next cycle, and all registers read 0.

Source files
------------

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - memory-mapped LED PWM / pattern sequencer
//
// Purpose: drives one LED either as a plain PWM output or as a 32-bit serial
// pattern gated by PWM. A small register window on a valid/ready bus holds
// the control, prescale, pattern and duty settings plus a status word.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   iomem_valid  bus request
//   iomem_wstrb  byte write strobes, all zero = read
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_ready  one-cycle acknowledge
//   iomem_rdata  read data, zero whenever iomem_ready is low
//   led          registered LED drive
//
// Register map (byte offsets inside the 256-byte window):
//   0x00 CTRL      [0] EN, [1] MODE (1 = pattern), [2] LOOP
//   0x04 PRESCALE  [23:0], tick every PRESCALE+1 cycles
//   0x08 PATTERN   [31:0]
//   0x0C DUTY      [7:0]
//   0x10 STATUS    [0] BUSY, [1] DONE (write 1 to clear), [12:8] bit index
//   0x14-0xFC      read 0, writes ignored

module led_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        led
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic        mode_q, mode_d;
    logic        loop_q, loop_d;
    logic [23:0] prescale_q, prescale_d;
    logic [31:0] pattern_q, pattern_d;
    logic [7:0]  duty_q, duty_d;
    logic        done_q, done_d;
    logic [23:0] presc_cnt_q, presc_cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  pwm_q, pwm_d;
    logic [31:0] shift_q, shift_d;
    logic        led_q, led_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    logic        sel;
    logic        access;
    logic        wr;
    logic [5:0]  word_off;
    logic        tick;
    logic        pwm_on;
    logic        bit_on;
    logic [31:0] rd_word;

    always_comb begin
        sel      = (iomem_addr[31:8] == BASE_ADDR[31:8]);
        // A new access starts only while no acknowledge is in flight, so a
        // master holding valid across ready never gets a double commit.
        access   = iomem_valid & sel & ~ready_q;
        wr       = access & (|iomem_wstrb);
        word_off = iomem_addr[7:2];

        case (word_off)
            6'h00:   rd_word = {29'd0, loop_q, mode_q, en_q};
            6'h01:   rd_word = {8'd0, prescale_q};
            6'h02:   rd_word = pattern_q;
            6'h03:   rd_word = {24'd0, duty_q};
            6'h04:   rd_word = {19'd0, idx_q, 6'd0, done_q, (state_q == S_RUN)};
            default: rd_word = 32'd0;
        endcase

        state_d     = state_q;
        en_d        = en_q;
        mode_d      = mode_q;
        loop_d      = loop_q;
        prescale_d  = prescale_q;
        pattern_d   = pattern_q;
        duty_d      = duty_q;
        done_d      = done_q;
        presc_cnt_d = presc_cnt_q;
        idx_d       = idx_q;
        pwm_d       = pwm_q;
        shift_d     = shift_q;

        ready_d = access;
        rdata_d = (access && !wr) ? rd_word : 32'd0;

        pwm_on = (pwm_q < duty_q);
        bit_on = mode_q ? shift_q[idx_q] : 1'b1;
        led_d  = (state_q == S_RUN) & pwm_on & bit_on;

        // Compare with >= so a PRESCALE lowered below the running count
        // ticks immediately instead of wrapping through 2^24.
        tick = (presc_cnt_q >= prescale_q);

        if (state_q == S_RUN) begin
            pwm_d = pwm_q + 8'd1;
            if (tick) begin
                presc_cnt_d = 24'd0;
                if (idx_q == 5'd31) begin
                    idx_d = 5'd0;
                    if (loop_q) begin
                        shift_d = pattern_q;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        en_d    = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end else begin
                presc_cnt_d = presc_cnt_q + 24'd1;
            end
        end

        // Register writes come last so a CTRL write overrides a coinciding tick.
        if (wr) begin
            case (word_off)
                6'h00: begin
                    if (iomem_wstrb[0]) begin
                        en_d   = iomem_wdata[0];
                        mode_d = iomem_wdata[1];
                        loop_d = iomem_wdata[2];
                        if (iomem_wdata[0]) begin
                            state_d     = S_RUN;
                            presc_cnt_d = 24'd0;
                            idx_d       = 5'd0;
                            pwm_d       = 8'd0;
                            done_d      = 1'b0;
                            shift_d     = pattern_q;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                6'h01: begin
                    for (int i = 0; i < 3; i++) begin
                        if (iomem_wstrb[i]) prescale_d[8*i +: 8] = iomem_wdata[8*i +: 8];
                    end
                end
                6'h02: begin
                    for (int i = 0; i < 4; i++) begin
                        if (iomem_wstrb[i]) pattern_d[8*i +: 8] = iomem_wdata[8*i +: 8];
                    end
                end
                6'h03: begin
                    if (iomem_wstrb[0]) duty_d = iomem_wdata[7:0];
                end
                6'h04: begin
                    if (iomem_wstrb[0] && iomem_wdata[1]) done_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            en_q        <= 1'b0;
            mode_q      <= 1'b0;
            loop_q      <= 1'b0;
            prescale_q  <= 24'd0;
            pattern_q   <= 32'd0;
            duty_q      <= 8'd0;
            done_q      <= 1'b0;
            presc_cnt_q <= 24'd0;
            idx_q       <= 5'd0;
            pwm_q       <= 8'd0;
            shift_q     <= 32'd0;
            led_q       <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            mode_q      <= mode_d;
            loop_q      <= loop_d;
            prescale_q  <= prescale_d;
            pattern_q   <= pattern_d;
            duty_q      <= duty_d;
            done_q      <= done_d;
            presc_cnt_q <= presc_cnt_d;
            idx_q       <= idx_d;
            pwm_q       <= pwm_d;
            shift_q     <= shift_d;
            led_q       <= led_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign led         = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - self-checking bench for led_sequencer

module tb_led_sequencer;

    localparam logic [31:0] BASE = 32'h0300_0100;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PRE  = BASE + 32'h04;
    localparam logic [31:0] A_PAT  = BASE + 32'h08;
    localparam logic [31:0] A_DUTY = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic [3:0]  iomem_wstrb = 4'd0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        led;

    int tests_run = 0;
    int tests_failed = 0;

    led_sequencer #(.BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_ready (iomem_ready),
        .iomem_rdata (iomem_rdata),
        .led         (led)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: LED value for cycle t of a run (t=0 is the first cycle in RUN).
    // L = PRESCALE+1 cycles per bit; pattern p_new is used from epoch new_ep on.
    function automatic logic exp_led(input int t, input int L, input logic mode,
                                     input logic loop, input logic [7:0] duty,
                                     input logic [31:0] p_old, input logic [31:0] p_new,
                                     input int new_ep);
        int ep;
        int bi;
        logic [31:0] pat;
        if (!loop && t >= 32 * L) return 1'b0;
        ep  = t / (32 * L);
        pat = (ep >= new_ep) ? p_new : p_old;
        bi  = (t / L) % 32;
        return ((t % 256) < int'(duty)) && (mode ? pat[bi] : 1'b1);
    endfunction

    // One bus access starting at the next falling edge; lat = -1 if no ready.
    task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output int lat);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wdata;
        lat   = -1;
        rdata = 32'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (iomem_ready === 1'b1) begin
                lat   = c;
                rdata = iomem_rdata;
                break;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        int l;
        bus(addr, 4'hF, data, d, l);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output int lat);
        bus(addr, 4'h0, 32'd0, data, lat);
    endtask

    // Called right after the enabling CTRL write returns; checks led for n
    // cycles. If kw >= 0 a PATTERN write of p_new is issued at cycle kw.
    task automatic run_check(input int n, input int L, input logic mode, input logic loop,
                             input logic [7:0] duty, input logic [31:0] p_old,
                             input int kw, input logic [31:0] p_new,
                             output int errs, output int ones);
        int new_ep;
        logic e;
        errs = 0;
        ones = 0;
        new_ep = (kw < 0) ? (1 << 30) : (kw + 2 + 32 * L - 1) / (32 * L);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = exp_led(k - 1, L, mode, loop, duty, p_old, p_new, new_ep);
            if (led !== e) errs++;
            if (led === 1'b1) ones++;
            if (k == kw) begin
                iomem_valid = 1'b1;
                iomem_addr  = A_PAT;
                iomem_wstrb = 4'hF;
                iomem_wdata = p_new;
            end
            if (kw >= 0 && k == kw + 1) begin
                if (iomem_ready !== 1'b1) errs++;
                iomem_valid = 1'b0;
                iomem_wstrb = 4'd0;
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int l;
        if (led !== 1'b0 || iomem_ready !== 1'b0 || iomem_rdata !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: led=%b ready=%b rdata=%h, required 0/0/0",
                     led, iomem_ready, iomem_rdata);
        end
        tests_run++;
        for (int i = 0; i < 5; i++) begin
            rd(BASE + 32'(4 * i), d, l);
            tests_run++;
            if (d !== 32'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_read off=%0h: got %h, required 0", 4 * i, d);
            end
            tests_run++;
            if (l !== 1) begin
                tests_failed++;
                $display("[TB] FAIL reset_latency off=%0h: got %0d, required 1", 4 * i, l);
            end
        end
    endtask

    task automatic test_pwm;
        int errs;
        int ones;
        logic [7:0] duties[3];
        duties[0] = 8'd255;
        duties[1] = 8'd128;
        duties[2] = 8'($urandom_range(1, 254));
        wr(A_PRE, 32'd1000);
        for (int i = 0; i < 3; i++) begin
            wr(A_DUTY, {24'd0, duties[i]});
            wr(A_CTRL, 32'h1);
            run_check(256, 1001, 1'b0, 1'b0, duties[i], 32'd0, -1, 32'd0, errs, ones);
            tests_run++;
            if (errs !== 0) begin
                tests_failed++;
                $display("[TB] FAIL pwm_trace duty=%0d: %0d bad cycles, required 0", duties[i], errs);
            end
            tests_run++;
            if (ones !== int'(duties[i])) begin
                tests_failed++;
                $display("[TB] FAIL pwm_count duty=%0d: got %0d high, required %0d",
                         duties[i], ones, duties[i]);
            end
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_pattern_once;
        int errs;
        int ones;
        int l;
        logic [31:0] d;
        wr(A_PAT, 32'h5);
        wr(A_PRE, 32'd3);
        wr(A_DUTY, 32'd255);
        wr(A_CTRL, 32'h3);
        run_check(140, 4, 1'b1, 1'b0, 8'd255, 32'h5, -1, 32'd0, errs, ones);
        tests_run++;
        if (errs !== 0) begin
            tests_failed++;
            $display("[TB] FAIL pattern_trace: %0d bad cycles, required 0", errs);
        end
        tests_run++;
        if (led !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pattern_led_done: got %b, required 0", led);
        end
        rd(A_STAT, d, l);
        tests_run++;
        if (d !== 32'h2) begin
            tests_failed++;
            $display("[TB] FAIL pattern_status: got %h, required 00000002", d);
        end
        rd(A_CTRL, d, l);
        tests_run++;
        if (d !== 32'h2) begin
            tests_failed++;
            $display("[TB] FAIL pattern_ctrl_en_clear: got %h, required 00000002", d);
        end
        wr(A_STAT, 32'h2);
        rd(A_STAT, d, l);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL done_w1c: got %h, required 00000000", d);
        end
    endtask

    task automatic test_loop_reload;
        int errs;
        int ones;
        int l;
        logic [31:0] d;
        wr(A_PAT, 32'h5);
        wr(A_PRE, 32'd3);
        wr(A_DUTY, 32'd255);
        wr(A_CTRL, 32'h7);
        run_check(300, 4, 1'b1, 1'b1, 8'd255, 32'h5, 50, 32'hFFFF_FFFF, errs, ones);
        tests_run++;
        if (errs !== 0) begin
            tests_failed++;
            $display("[TB] FAIL loop_reload_trace: %0d bad cycles, required 0", errs);
        end
        rd(A_STAT, d, l);
        tests_run++;
        if (d[1:0] !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL loop_busy: got status %h, required busy=1 done=0", d);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_en_stop;
        int l;
        logic [31:0] d;
        wr(A_PRE, 32'd1000);
        wr(A_DUTY, 32'd255);
        wr(A_CTRL, 32'h5);
        repeat (5) @(negedge clk);
        wr(A_CTRL, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (led !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL en_stop_led cycle %0d: got %b, required 0", k, led);
            end
        end
        rd(A_STAT, d, l);
        tests_run++;
        if (d[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL en_stop_busy: got %b, required 0", d[0]);
        end
    endtask

    task automatic test_strobe;
        logic [31:0] d;
        logic [31:0] data;
        logic [31:0] expv;
        logic [3:0]  strb;
        logic [7:0]  off;
        int l;
        bus(A_PAT, 4'b0000, 32'd0, d, l);
        wr(A_PAT, 32'd0);
        bus(A_PAT, 4'b0001, 32'hAABB_CCDD, d, l);
        rd(A_PAT, d, l);
        tests_run++;
        if (d !== 32'h0000_00DD) begin
            tests_failed++;
            $display("[TB] FAIL strobe_pattern: got %h, required 000000dd", d);
        end
        for (int i = 0; i < 3; i++) begin
            wr(A_PRE, 32'd0);
            data = $urandom;
            strb = 4'($urandom_range(1, 15));
            expv = 32'd0;
            for (int b = 0; b < 3; b++) if (strb[b]) expv[8*b +: 8] = data[8*b +: 8];
            bus(A_PRE, strb, data, d, l);
            rd(A_PRE, d, l);
            tests_run++;
            if (d !== expv) begin
                tests_failed++;
                $display("[TB] FAIL strobe_prescale strb=%b: got %h, required %h", strb, d, expv);
            end
        end
        wr(A_DUTY, 32'h33);
        bus(A_DUTY, 4'b1110, 32'hFFFF_FF99, d, l);
        rd(A_DUTY, d, l);
        tests_run++;
        if (d !== 32'h33) begin
            tests_failed++;
            $display("[TB] FAIL strobe_duty_lane: got %h, required 00000033", d);
        end
        wr(A_CTRL, 32'hFFFF_FFF8);
        rd(A_CTRL, d, l);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL ctrl_undefined_bits: got %h, required 00000000", d);
        end
        for (int i = 0; i < 3; i++) begin
            off = 8'(4 * $urandom_range(5, 63));
            wr(BASE + {24'd0, off}, $urandom);
            rd(BASE + {24'd0, off}, d, l);
            tests_run++;
            if (d !== 32'd0 || l !== 1) begin
                tests_failed++;
                $display("[TB] FAIL hole_read off=%h: got %h lat %0d, required 0 lat 1", off, d, l);
            end
        end
        rd(BASE + 32'h100, d, l);
        tests_run++;
        if (l !== -1) begin
            tests_failed++;
            $display("[TB] FAIL unselected_ready: got latency %0d, required none", l);
        end
        rd(BASE - 32'h4, d, l);
        tests_run++;
        if (l !== -1) begin
            tests_failed++;
            $display("[TB] FAIL unselected_below: got latency %0d, required none", l);
        end
    endtask

    task automatic test_abandon;
        logic [31:0] d;
        int l;
        int seen;
        wr(A_DUTY, 32'h11);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = A_DUTY;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h77;
        #2;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (iomem_ready === 1'b1) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("[TB] FAIL abandon_ready: got %0d acks, required 0", seen);
        end
        rd(A_DUTY, d, l);
        tests_run++;
        if (d !== 32'h11) begin
            tests_failed++;
            $display("[TB] FAIL abandon_write: got %h, required 00000011", d);
        end
    endtask

    task automatic test_random_runs;
        int errs;
        int ones;
        int l;
        logic [31:0] d;
        logic [31:0] pat;
        int p;
        logic [7:0] duty;
        logic mode;
        for (int i = 0; i < 3; i++) begin
            pat  = $urandom;
            p    = $urandom_range(0, 3);
            duty = 8'($urandom_range(0, 255));
            mode = 1'($urandom_range(0, 1));
            wr(A_PAT, pat);
            wr(A_PRE, 32'(p));
            wr(A_DUTY, {24'd0, duty});
            wr(A_CTRL, {30'd0, mode, 1'b1});
            run_check(32 * (p + 1) + 10, p + 1, mode, 1'b0, duty, pat, -1, 32'd0, errs, ones);
            tests_run++;
            if (errs !== 0) begin
                tests_failed++;
                $display("[TB] FAIL random_run %0d (pat=%h p=%0d duty=%0d mode=%b): %0d bad cycles, required 0",
                         i, pat, p, duty, mode, errs);
            end
            rd(A_STAT, d, l);
            tests_run++;
            if (d !== 32'h2) begin
                tests_failed++;
                $display("[TB] FAIL random_status %0d: got %h, required 00000002", i, d);
            end
        end
    endtask

    task automatic test_back_to_back;
        int errs;
        int ones;
        logic [31:0] pat;
        int p;
        logic [7:0] duty;
        for (int i = 0; i < 4; i++) begin
            pat  = $urandom;
            p    = (i < 2) ? 0 : $urandom_range(0, 2);
            duty = 8'($urandom_range(0, 255));
            wr(A_PAT, pat);
            wr(A_PRE, 32'(p));
            wr(A_DUTY, {24'd0, duty});
            wr(A_CTRL, 32'h7);
            run_check(100, p + 1, 1'b1, 1'b1, duty, pat, -1, 32'd0, errs, ones);
            tests_run++;
            if (errs !== 0) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back %0d (p=%0d): %0d bad cycles, required 0", i, p, errs);
            end
        end
    endtask

    task automatic test_reset_midrun;
        logic [31:0] d;
        int l;
        wr(A_PAT, 32'hFFFF_FFFF);
        wr(A_PRE, 32'd3);
        wr(A_DUTY, 32'd255);
        wr(A_CTRL, 32'h7);
        repeat (10) @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = A_DUTY;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h55;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (iomem_ready !== 1'b0 || led !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_midrun_outputs: ready=%b led=%b, required 0/0", iomem_ready, led);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd(BASE + 32'(4 * i), d, l);
            tests_run++;
            if (d !== 32'd0 || l !== 1) begin
                tests_failed++;
                $display("[TB] FAIL reset_midrun_read off=%0h: got %h lat %0d, required 0 lat 1",
                         4 * i, d, l);
            end
        end
        @(negedge clk);
        tests_run++;
        if (led !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_midrun_led: got %b, required 0", led);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_pwm();
        test_pattern_once();
        test_loop_reload();
        test_en_stop();
        test_strobe();
        test_abandon();
        test_random_runs();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
